// File: rtl/picorv_vec_pkg.sv
// Shared types and defaults for the picorv32 / vector-coprocessor memory arbiter.
// Grant encoding doubles as the requester index into the per-requester arrays.
package picorv_vec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_CPU = 2'd1,
    ST_BUSY_VEC = 2'd2
  } arb_state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_VEC = 1'b1;
  localparam int   NUM_REQ = 2;

  localparam int          DEF_TIMEOUT     = 256;
  localparam logic [31:0] DEF_ABORT_RDATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  function automatic arb_state_t busy_state(input logic gnt);
    return gnt ? ST_BUSY_VEC : ST_BUSY_CPU;
  endfunction

endpackage

// File: rtl/picorv_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the side that did not win last time goes.
module picorv_rr_pick2
  import picorv_vec_pkg::*;
(
  input  logic req_cpu,
  input  logic req_vec,
  input  logic last_grant,
  output logic grant,
  output logic any
);

  always_comb begin
    any = req_cpu | req_vec;
    if (req_cpu && req_vec) grant = ~last_grant;
    else                    grant = req_vec ? GNT_VEC : GNT_CPU;
  end

endmodule

// File: rtl/picorv_vec_mem_arbiter.sv
// Arbitrates one memory port between the picorv32 core and the vector coprocessor.
// One transfer per grant; a watchdog aborts transfers the memory never acknowledges.
module picorv_vec_mem_arbiter
  import picorv_vec_pkg::*;
#(
  parameter int          TIMEOUT     = DEF_TIMEOUT,
  parameter logic [31:0] ABORT_RDATA = DEF_ABORT_RDATA
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_mem_valid,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  input  logic        vec_mem_valid,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic        vec_mem_ready,
  output logic [31:0] vec_mem_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        grant_vec,
  output logic        timeout_err
);

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic [WD_W-1:0] wdog;
  logic       pick_gnt, pick_any;
  logic       busy, owner, wd_hit, done, abort;

  mem_req_t [NUM_REQ-1:0]        req;
  mem_req_t                      sel;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][31:0]      req_rdata;

  assign req[GNT_CPU] = '{addr: cpu_mem_addr, wdata: cpu_mem_wdata, wstrb: cpu_mem_wstrb};
  assign req[GNT_VEC] = '{addr: vec_mem_addr, wdata: vec_mem_wdata, wstrb: vec_mem_wstrb};

  picorv_rr_pick2 u_pick (
    .req_cpu    (cpu_mem_valid),
    .req_vec    (vec_mem_valid),
    .last_grant (last_grant),
    .grant      (pick_gnt),
    .any        (pick_any)
  );

  assign busy   = (state != ST_IDLE);
  assign owner  = (state == ST_BUSY_VEC);
  assign wd_hit = (wdog == WD_LAST);
  // A late mem_ready landing on the final watchdog cycle still counts as a real completion.
  assign done   = busy && (mem_ready || wd_hit);
  assign abort  = busy && !mem_ready && wd_hit;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nxt      = busy_state(pick_gnt);
          last_grant_nxt = pick_gnt;
        end
      end
      ST_BUSY_CPU, ST_BUSY_VEC: begin
        if (done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      last_grant  <= GNT_VEC;
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      timeout_err <= timeout_err | abort;
      if (!busy)          wdog <= '0;
      else if (!mem_ready) wdog <= wdog + 1'b1;
    end
  end

  // mem_valid is a pure decode of the state register, so it is glitch-free and drops on reset.
  assign mem_valid = busy;
  assign grant_vec = owner;
  assign sel       = busy ? req[owner] : '0;
  assign mem_addr  = sel.addr;
  assign mem_wdata = sel.wdata;
  assign mem_wstrb = sel.wstrb;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
    assign req_ready[g] = done && (owner == 1'(g));
    assign req_rdata[g] = !req_ready[g] ? '0 : (mem_ready ? mem_rdata : ABORT_RDATA);
  end

  assign cpu_mem_ready = req_ready[GNT_CPU];
  assign cpu_mem_rdata = req_rdata[GNT_CPU];
  assign vec_mem_ready = req_ready[GNT_VEC];
  assign vec_mem_rdata = req_rdata[GNT_VEC];

endmodule
